// File: rtl/hamnhan_seq_mul_core.sv
// hamnhan_seq_mul_core: sequential shift-add multiplier, one multiplier bit per clock
// Ports: S_AXI_ACLK clock, S_AXI_ARESETN async active-low reset, clr sync soft clear,
//   in_valid/in_ready/in_a/in_b operand channel, out_valid/out_ready/out_p product channel,
//   busy high while computing or holding a result.
module hamnhan_seq_mul_core #(
  parameter int OP_WIDTH    = 16,
  parameter bit SIGNED_MODE = 1'b0
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_WIDTH-1:0]     in_a,
  input  logic [OP_WIDTH-1:0]     in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*OP_WIDTH-1:0]   out_p,
  output logic                    busy
);
  localparam int PW = 2 * OP_WIDTH;
  localparam int CW = OP_WIDTH > 1 ? $clog2(OP_WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [PW-1:0] a_sh, acc, acc_nxt;
  logic [OP_WIDTH-1:0] b_sh, mag_a, mag_b;
  logic [CW-1:0] cnt;
  logic sgn;
  // Magnitudes are held unsigned, so the most negative operand maps to 2^(OP_WIDTH-1).
  always_comb begin
    mag_a = (SIGNED_MODE && in_a[OP_WIDTH-1]) ? -in_a : in_a;
    mag_b = (SIGNED_MODE && in_b[OP_WIDTH-1]) ? -in_b : in_b;
    acc_nxt = b_sh[0] ? acc + a_sh : acc;
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_p     <= '0;
      busy      <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      acc       <= '0;
      cnt       <= '0;
      sgn       <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh     <= PW'(mag_a);
          b_sh     <= mag_b;
          sgn      <= SIGNED_MODE && (in_a[OP_WIDTH-1] ^ in_b[OP_WIDTH-1]);
          acc      <= '0;
          cnt      <= '0;
          state    <= CALC;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        CALC: begin
          acc  <= acc_nxt;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CW'(1);
          // Last iteration: fold in this cycle's partial product directly.
          if (cnt == CW'(OP_WIDTH - 1)) begin
            out_p     <= sgn ? -acc_nxt : acc_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hamnhan_seq_mul_core.sv
// tb_hamnhan_seq_mul_core: scoreboard bench driving an unsigned and a signed core in lockstep
module tb_hamnhan_seq_mul_core;
  localparam int W = 16;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b1, rnd_bp = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic ir_u, ov_u, busy_u, ir_s, ov_s, busy_s;
  logic [2*W-1:0] p_u, p_s;
  typedef struct {logic [31:0] pu; logic [31:0] ps; int c;} exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0, cyc = 0;
  logic prev_v = 1'b0, prev_hs = 1'b0;
  logic [31:0] last_u = '0, last_s = '0;
  always #5 clk = ~clk;
  hamnhan_seq_mul_core #(.OP_WIDTH(W), .SIGNED_MODE(1'b0)) dut_u (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir_u),
    .in_a(in_a), .in_b(in_b), .out_valid(ov_u), .out_ready(out_ready), .out_p(p_u), .busy(busy_u));
  hamnhan_seq_mul_core #(.OP_WIDTH(W), .SIGNED_MODE(1'b1)) dut_s (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir_s),
    .in_a(in_a), .in_b(in_b), .out_valid(ov_s), .out_ready(out_ready), .out_p(p_s), .busy(busy_s));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 32'(sa * sb);
  endfunction
  always @(negedge clk) begin
    cyc++;
    if (!rst_n || clr) begin
      q.delete();
      prev_v = 1'b0;
      prev_hs = 1'b0;
    end else begin
      chk("valid_match", 32'(ov_s), 32'(ov_u));
      chk("ready_match", 32'(ir_s), 32'(ir_u));
      chk("busy_match", 32'(busy_s), 32'(busy_u));
      if (prev_v && !prev_hs) begin
        chk("hold_valid", 32'(ov_u), 32'd1);
        chk("hold_p_u", p_u, last_u);
        chk("hold_p_s", p_s, last_s);
      end
      if (ov_u) begin
        chk("in_ready_done", 32'(ir_u), 32'd0);
        if (q.size() == 0) chk("spurious_valid", 32'(ov_u), 32'd0);
        else begin
          if (!prev_v) chk("latency", 32'(cyc - q[0].c), 32'd17);
          if (out_ready) begin
            chk("prod_u", p_u, q[0].pu);
            chk("prod_s", p_s, q[0].ps);
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && ir_u) q.push_back('{32'(in_a) * 32'(in_b), smul(in_a, in_b), cyc});
      prev_hs = ov_u && out_ready;
      prev_v = ov_u;
      last_u = p_u;
      last_s = p_s;
    end
  end
  always @(posedge clk) if (rnd_bp) begin
    #1;
    out_ready = 1'($urandom_range(0, 1));
  end
  task automatic sync();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!ir_u && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) chk("drain_timeout", 32'(q.size()), 32'd0);
    sync();
  endtask
  task automatic chk_idle(input string n);
    chk({n, "_in_ready"}, 32'(ir_u), 32'd1);
    chk({n, "_out_valid"}, 32'(ov_u), 32'd0);
    chk({n, "_busy"}, 32'(busy_u), 32'd0);
  endtask
  logic [W-1:0] dir_a [6] = '{16'hFFFF, 16'hFFFD, 16'h8000, 16'h8000, 16'h0000, 16'h1234};
  logic [W-1:0] dir_b [6] = '{16'hFFFF, 16'h0007, 16'h8000, 16'h0001, 16'h1234, 16'h0001};
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    chk("reset_p_u", p_u, 32'd0);
    chk("reset_p_s", p_s, 32'd0);
    rst_n = 1'b1;
    sync();
    for (int i = 0; i < 6; i++) begin
      op(dir_a[i], dir_b[i]);
      drain();
    end
    out_ready = 1'b0;
    op(16'h1234, 16'h5678);
    begin
      int n = 0;
      while (!ov_u && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) chk("bp_valid_timeout", 32'(n), 32'd0);
    end
    repeat (10) @(posedge clk);
    #1;
    chk("bp_in_ready", 32'(ir_u), 32'd0);
    chk("bp_busy", 32'(busy_u), 32'd1);
    chk("bp_valid", 32'(ov_u), 32'd1);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_a = 16'h00FF;
    in_b = 16'h0101;
    @(posedge clk);
    @(negedge clk);
    chk_idle("bp_release");
    @(posedge clk);
    #1;
    chk("bp_new_accept_ready", 32'(ir_u), 32'd0);
    chk("bp_new_accept_busy", 32'(busy_u), 32'd1);
    in_valid = 1'b0;
    drain();
    in_a = 16'h0123;
    in_b = 16'h0456;
    in_valid = 1'b1;
    wait_accept();
    in_a = 16'hF00D;
    in_b = 16'h0BAD;
    wait_accept();
    in_valid = 1'b0;
    drain();
    rnd_bp = 1'b1;
    repeat (30) op(16'($urandom), 16'($urandom));
    rnd_bp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    op(16'h0007, 16'h0009);
    repeat (5) @(posedge clk);
    #1;
    clr = 1'b1;
    sync();
    clr = 1'b0;
    chk_idle("clr_calc");
    repeat (25) @(posedge clk);
    #1;
    op(16'd3, 16'd5);
    drain();
    clr = 1'b1;
    in_valid = 1'b1;
    in_a = 16'h0042;
    in_b = 16'h0042;
    sync();
    clr = 1'b0;
    in_valid = 1'b0;
    chk_idle("clr_in_valid");
    repeat (20) @(posedge clk);
    #1;
    op(16'hABCD, 16'h1357);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_p_u", p_u, 32'd0);
    chk("async_rst_p_s", p_s, 32'd0);
    chk("async_rst_busy_s", 32'(busy_s), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sync();
    op(16'd100, 16'd200);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
